// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default widths for the memory arbiter
package mem_pkg;

   localparam int MEM_ADDR_WIDTH   = 32;
   localparam int MEM_DATA_WIDTH   = 32;
   localparam int MEM_STARVE_LIMIT = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_REQ  = 3'd1,
      I_RESP = 3'd2,
      D_REQ  = 3'd3,
      D_RESP = 3'd4
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// rtl/mem_arbiter_starve_counter.sv - saturating count of data grants taken while a fetch waits
module starve_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign at_limit_o = (cnt_q == CW'(STARVE_LIMIT));

   // Clear wins over increment; the count never runs past the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !at_limit_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
   parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  imem_req_i,
   input  logic [ADDR_WIDTH-1:0] imem_addr_i,
   input  logic                  imem_flush_i,
   output logic [DATA_WIDTH-1:0] imem_rdata_o,
   output logic                  imem_ready_o,
   input  logic                  dmem_req_i,
   input  logic                  dmem_we_i,
   input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
   input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
   output logic [DATA_WIDTH-1:0] dmem_rdata_o,
   output logic                  dmem_ready_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  stall_if_o,
   output logic                  stall_mem_o,
   output logic                  busy_o
);

   arb_state_e            state_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  busy_q;
   logic                  drop_q;
   logic [DATA_WIDTH-1:0] imem_hold_q;
   logic [DATA_WIDTH-1:0] imem_hold_d;
   logic [DATA_WIDTH-1:0] dmem_hold_q;
   logic [DATA_WIDTH-1:0] dmem_hold_d;

   logic at_limit;
   logic pick_data;
   logic pick_fetch;
   logic cnt_inc;
   logic cnt_clr;
   logic imem_resp;
   logic dmem_resp;

   // Data wins unless fetch has already been passed over STARVE_LIMIT times.
   assign pick_data  = dmem_req_i && (!imem_req_i || !at_limit);
   assign pick_fetch = !pick_data && imem_req_i;
   assign cnt_inc    = (state_q == IDLE) && pick_data && imem_req_i;
   assign cnt_clr    = (state_q == IDLE) && (pick_fetch || !imem_req_i);

   starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (cnt_inc),
      .clr_i      (cnt_clr),
      .at_limit_o (at_limit)
   );

   assign imem_resp = (state_q == I_RESP) && mem_rvalid_i && !rst_i;
   assign dmem_resp = (state_q == D_RESP) && mem_rvalid_i && !rst_i;

   // A redirect arriving together with the response still discards it.
   assign imem_ready_o = imem_resp && !drop_q && !imem_flush_i;
   assign dmem_ready_o = dmem_resp;

   assign imem_rdata_o = imem_resp ? mem_rdata_i : imem_hold_q;
   assign dmem_rdata_o = dmem_resp ? mem_rdata_i : dmem_hold_q;

   assign imem_hold_d = imem_ready_o ? mem_rdata_i : imem_hold_q;
   assign dmem_hold_d = dmem_ready_o ? mem_rdata_i : dmem_hold_q;

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;

   assign stall_if_o  = imem_req_i && !imem_ready_o;
   assign stall_mem_o = dmem_req_i && !dmem_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         imem_hold_q <= '0;
         dmem_hold_q <= '0;
      end else begin
         imem_hold_q <= imem_hold_d;
         dmem_hold_q <= dmem_hold_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_data) begin
                  state_q     <= D_REQ;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= dmem_we_i;
                  mem_addr_q  <= dmem_addr_i;
                  mem_wdata_q <= dmem_wdata_i;
                  busy_q      <= 1'b1;
               end else if (pick_fetch) begin
                  state_q    <= I_REQ;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= imem_addr_i;
                  busy_q     <= 1'b1;
               end
            end
            I_REQ: begin
               if (mem_gnt_i) begin
                  state_q   <= I_RESP;
                  mem_req_q <= 1'b0;
                  drop_q    <= imem_flush_i;
               end else if (imem_flush_i) begin
                  // Not yet accepted, so the fetch can be withdrawn outright.
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
            I_RESP: begin
               if (mem_rvalid_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  drop_q  <= 1'b0;
               end else if (imem_flush_i) begin
                  drop_q <= 1'b1;
               end
            end
            D_REQ: begin
               if (mem_gnt_i) begin
                  state_q   <= D_RESP;
                  mem_req_q <= 1'b0;
               end
            end
            D_RESP: begin
               if (mem_rvalid_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
               busy_q    <= 1'b0;
               drop_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_i;
   logic [31:0] imem_addr_i;
   logic        imem_flush_i;
   logic [31:0] imem_rdata_o;
   logic        imem_ready_o;
   logic        dmem_req_i;
   logic        dmem_we_i;
   logic [31:0] dmem_addr_i;
   logic [31:0] dmem_wdata_i;
   logic [31:0] dmem_rdata_o;
   logic        dmem_ready_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        stall_if_o;
   logic        stall_mem_o;
   logic        busy_o;

   int n_tests  = 0;
   int n_failed = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .imem_req_i   (imem_req_i),
      .imem_addr_i  (imem_addr_i),
      .imem_flush_i (imem_flush_i),
      .imem_rdata_o (imem_rdata_o),
      .imem_ready_o (imem_ready_o),
      .dmem_req_i   (dmem_req_i),
      .dmem_we_i    (dmem_we_i),
      .dmem_addr_i  (dmem_addr_i),
      .dmem_wdata_i (dmem_wdata_i),
      .dmem_rdata_o (dmem_rdata_o),
      .dmem_ready_o (dmem_ready_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .stall_if_o   (stall_if_o),
      .stall_mem_o  (stall_mem_o),
      .busy_o       (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   initial begin
      int          got;
      logic [5:0]  order;

      rst_i        = 1'b1;
      imem_req_i   = 1'b0;
      imem_addr_i  = '0;
      imem_flush_i = 1'b0;
      dmem_req_i   = 1'b0;
      dmem_we_i    = 1'b0;
      dmem_addr_i  = '0;
      dmem_wdata_i = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      cyc();
      cyc();
      smp();
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_imem_rdata", imem_rdata_o, 32'h0);

      // Lone fetch with immediate grant and response
      cyc();
      rst_i       = 1'b0;
      imem_req_i  = 1'b1;
      imem_addr_i = 32'h0000_0040;
      mem_gnt_i   = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 32'h2008_0005;
      smp();
      chk("f_c0_stall_if", stall_if_o, 1'b1);
      chk("f_c0_mem_req", mem_req_o, 1'b0);
      cyc();
      smp();
      chk("f_c1_mem_req", mem_req_o, 1'b1);
      chk("f_c1_addr", mem_addr_o, 32'h0000_0040);
      chk("f_c1_we", mem_we_o, 1'b0);
      chk("f_c1_stall_if", stall_if_o, 1'b1);
      cyc();
      smp();
      chk("f_c2_ready", imem_ready_o, 1'b1);
      chk("f_c2_rdata", imem_rdata_o, 32'h2008_0005);
      chk("f_c2_stall_if", stall_if_o, 1'b0);
      cyc();
      imem_req_i  = 1'b0;
      mem_rdata_i = 32'h0;
      smp();
      chk("f_c3_ready", imem_ready_o, 1'b0);
      chk("f_c3_hold", imem_rdata_o, 32'h2008_0005);
      chk("f_c3_busy", busy_o, 1'b0);

      // Fetch and store together: store goes first
      cyc();
      imem_req_i   = 1'b1;
      imem_addr_i  = 32'h0000_0044;
      dmem_req_i   = 1'b1;
      dmem_we_i    = 1'b1;
      dmem_addr_i  = 32'h0000_0100;
      dmem_wdata_i = 32'hDEAD_BEEF;
      smp();
      chk("sw_c0_stall_mem", stall_mem_o, 1'b1);
      cyc();
      smp();
      chk("sw_c1_mem_req", mem_req_o, 1'b1);
      chk("sw_c1_we", mem_we_o, 1'b1);
      chk("sw_c1_addr", mem_addr_o, 32'h0000_0100);
      chk("sw_c1_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      chk("sw_c1_stall_if", stall_if_o, 1'b1);
      cyc();
      smp();
      chk("sw_c2_dready", dmem_ready_o, 1'b1);
      chk("sw_c2_iready", imem_ready_o, 1'b0);
      cyc();
      dmem_req_i = 1'b0;
      smp();
      chk("sw_c3_mem_req", mem_req_o, 1'b0);
      cyc();
      mem_rdata_i = 32'h8C01_0000;
      smp();
      chk("sw_c4_mem_req", mem_req_o, 1'b1);
      chk("sw_c4_addr", mem_addr_o, 32'h0000_0044);
      chk("sw_c4_we", mem_we_o, 1'b0);
      cyc();
      smp();
      chk("sw_c5_iready", imem_ready_o, 1'b1);
      chk("sw_c5_rdata", imem_rdata_o, 32'h8C01_0000);
      cyc();
      imem_req_i = 1'b0;
      smp();

      // Starvation guard with limit 2: D, D, I, D, D, I
      cyc();
      imem_req_i  = 1'b1;
      imem_addr_i = 32'h0000_0048;
      dmem_req_i  = 1'b1;
      dmem_we_i   = 1'b0;
      dmem_addr_i = 32'h0000_0104;
      mem_rdata_i = 32'hCAFE_0003;
      got   = 0;
      order = '0;
      for (int k = 0; k < 40 && got < 6; k++) begin
         smp();
         if (dmem_ready_o) begin
            order[5-got] = 1'b1;
            got++;
         end else if (imem_ready_o) begin
            order[5-got] = 1'b0;
            got++;
         end
         cyc();
      end
      imem_req_i = 1'b0;
      dmem_req_i = 1'b0;
      chk("starve_count", got, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("starve_grant%0d", i), order[5-i], (i == 2 || i == 5) ? 1'b0 : 1'b1);
      end
      smp();

      // Flush while waiting for the response
      cyc();
      imem_req_i   = 1'b1;
      imem_addr_i  = 32'h0000_0060;
      mem_rvalid_i = 1'b0;
      smp();
      cyc();
      smp();
      chk("fl_c1_addr", mem_addr_o, 32'h0000_0060);
      cyc();
      imem_flush_i = 1'b1;
      imem_req_i   = 1'b0;
      smp();
      chk("fl_c2_busy", busy_o, 1'b1);
      chk("fl_c2_ready", imem_ready_o, 1'b0);
      cyc();
      imem_flush_i = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1234_5678;
      smp();
      chk("fl_c3_ready", imem_ready_o, 1'b0);
      chk("fl_c3_busy", busy_o, 1'b1);
      cyc();
      imem_req_i  = 1'b1;
      imem_addr_i = 32'h0000_0080;
      mem_rdata_i = 32'hAC02_0004;
      smp();
      chk("fl_c4_busy", busy_o, 1'b0);
      chk("fl_c4_hold", imem_rdata_o, 32'hCAFE_0003);
      cyc();
      smp();
      chk("fl_c5_mem_req", mem_req_o, 1'b1);
      chk("fl_c5_addr", mem_addr_o, 32'h0000_0080);
      cyc();
      smp();
      chk("fl_c6_ready", imem_ready_o, 1'b1);
      chk("fl_c6_rdata", imem_rdata_o, 32'hAC02_0004);
      cyc();
      imem_req_i = 1'b0;
      smp();

      // Load with grant withheld for 5 cycles
      cyc();
      dmem_req_i  = 1'b1;
      dmem_we_i   = 1'b0;
      dmem_addr_i = 32'h0000_0200;
      mem_gnt_i   = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 32'h0;
      smp();
      for (int i = 0; i < 5; i++) begin
         cyc();
         dmem_addr_i = 32'h0000_0200 ^ ((i + 1) << 4);
         smp();
         chk($sformatf("lw_wait%0d_req", i), mem_req_o, 1'b1);
         chk($sformatf("lw_wait%0d_addr", i), mem_addr_o, 32'h0000_0200);
         chk($sformatf("lw_wait%0d_stall", i), stall_mem_o, 1'b1);
         chk($sformatf("lw_wait%0d_ready", i), dmem_ready_o, 1'b0);
      end
      cyc();
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b0;
      smp();
      chk("lw_gnt_req", mem_req_o, 1'b1);
      cyc();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h55AA_33CC;
      smp();
      chk("lw_resp_req", mem_req_o, 1'b0);
      chk("lw_resp_ready", dmem_ready_o, 1'b1);
      chk("lw_resp_rdata", dmem_rdata_o, 32'h55AA_33CC);
      chk("lw_resp_stall", stall_mem_o, 1'b0);
      cyc();
      dmem_req_i   = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      smp();
      chk("lw_hold", dmem_rdata_o, 32'h55AA_33CC);

      // Reset in D_RESP, response arrives one cycle late
      cyc();
      dmem_req_i   = 1'b1;
      dmem_we_i    = 1'b1;
      dmem_addr_i  = 32'h0000_0300;
      dmem_wdata_i = 32'h0102_0304;
      mem_gnt_i    = 1'b1;
      smp();
      cyc();
      smp();
      chk("rs_c1_req", mem_req_o, 1'b1);
      cyc();
      rst_i = 1'b1;
      smp();
      chk("rs_c2_busy", busy_o, 1'b1);
      cyc();
      rst_i        = 1'b0;
      dmem_req_i   = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h7777_7777;
      smp();
      chk("rs_c3_ready", dmem_ready_o, 1'b0);
      chk("rs_c3_req", mem_req_o, 1'b0);
      chk("rs_c3_busy", busy_o, 1'b0);
      chk("rs_c3_we", mem_we_o, 1'b0);
      chk("rs_c3_addr", mem_addr_o, 32'h0);
      chk("rs_c3_wdata", mem_wdata_o, 32'h0);
      chk("rs_c3_drdata", dmem_rdata_o, 32'h0);
      chk("rs_c3_irdata", imem_rdata_o, 32'h0);
      cyc();
      mem_rvalid_i = 1'b0;
      smp();
      chk("rs_c4_busy", busy_o, 1'b0);
      chk("rs_c4_req", mem_req_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
